// File: rtl/reg_file_pkg.sv
// Shared defaults and helpers for the register file, scoreboard and hazard logic.
package reg_file_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef logic [NREGS_DEF-1:0] busy_vec_t;

  function automatic int addr_w(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback-facing bus of the register file with scoreboard.
interface reg_file_sb_if import reg_file_pkg::*; #(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NREAD = 2
);
  localparam int AW = addr_w(NREGS);

  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  issue_valid;
  logic [AW-1:0]         issue_addr;
  logic                  issue_ready;
  logic                  wb_valid;
  logic [AW-1:0]         wb_addr;
  logic [XLEN-1:0]       wb_data;
  logic                  flush;
  logic [AW:0]           busy_count;

  modport master (
    output rd_addr, issue_valid, issue_addr, wb_valid, wb_addr, wb_data, flush,
    input  rd_data, rd_busy, issue_ready, busy_count
  );

  modport slave (
    input  rd_addr, issue_valid, issue_addr, wb_valid, wb_addr, wb_data, flush,
    output rd_data, rd_busy, issue_ready, busy_count
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register write-pending bits: one outstanding producer per register,
// flush beats a new claim, a new claim beats the retiring writeback.
module reg_scoreboard import reg_file_pkg::*; #(
  parameter int  NREGS    = NREGS_DEF,
  parameter bit  ZERO_REG = 1'b1,
  localparam int AW       = addr_w(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_addr,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_addr,
  input  logic             flush,
  output logic [NREGS-1:0] busy,
  output logic             issue_ready,
  output logic [AW:0]      busy_count
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;
  logic [AW:0]      count_nxt;
  logic             accept;
  logic             issue_is_zero;

  always_comb begin
    issue_is_zero = ZERO_REG && (issue_addr == '0);
    issue_ready   = issue_is_zero || !busy_q[issue_addr] ||
                    (wb_valid && (wb_addr == issue_addr));
    accept        = issue_valid && issue_ready && !flush;

    busy_nxt = busy_q;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wb_valid)
        busy_nxt[wb_addr] = 1'b0;
      if (accept && !issue_is_zero)
        busy_nxt[issue_addr] = 1'b1;
    end

    // Count the next state so the registered count tracks the bits exactly.
    count_nxt = '0;
    for (int r = 0; r < NREGS; r++)
      count_nxt = count_nxt + (AW+1)'(busy_nxt[r]);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_q     <= '0;
      busy_count <= '0;
    end else begin
      busy_q     <= busy_nxt;
      busy_count <= count_nxt;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with combinational read ports, writeback bypass, optional
// hardwired x0, and the write-pending scoreboard used for RAW detection.
module reg_file_sb import reg_file_pkg::*; #(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NREAD    = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  reg_file_sb_if.slave bus
);

  localparam int AW = addr_w(NREGS);

  logic [XLEN-1:0]       mem [NREGS];
  logic [NREGS-1:0]      busy;
  logic [NREAD*XLEN-1:0] rd_data_c;
  logic [NREAD-1:0]      rd_busy_c;
  logic [AW-1:0]         port_addr;
  logic                  port_hit;
  logic                  port_zero;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++)
        mem[r] <= '0;
    end else if (bus.wb_valid && !(ZERO_REG && (bus.wb_addr == '0))) begin
      mem[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    port_addr = '0;
    port_hit  = 1'b0;
    port_zero = 1'b0;
    for (int p = 0; p < NREAD; p++) begin
      port_addr = bus.rd_addr[p*AW +: AW];
      port_zero = ZERO_REG && (port_addr == '0);
      port_hit  = BYPASS && bus.wb_valid && (bus.wb_addr == port_addr);
      if (port_zero)
        rd_data_c[p*XLEN +: XLEN] = '0;
      else if (port_hit)
        rd_data_c[p*XLEN +: XLEN] = bus.wb_data;
      else
        rd_data_c[p*XLEN +: XLEN] = mem[port_addr];
      // A write landing this cycle satisfies the pending producer.
      rd_busy_c[p] = !port_zero && busy[port_addr] && !port_hit;
    end
  end

  assign bus.rd_data = rd_data_c;
  assign bus.rd_busy = rd_busy_c;

  reg_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .reset_n     (reset_n),
    .issue_valid (bus.issue_valid),
    .issue_addr  (bus.issue_addr),
    .wb_valid    (bus.wb_valid),
    .wb_addr     (bus.wb_addr),
    .flush       (bus.flush),
    .busy        (busy),
    .issue_ready (bus.issue_ready),
    .busy_count  (bus.busy_count)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: default 32x32 instance against a behavioural model,
// plus a 16x64, 3-port, no-x0 instance with directed checks.
module tb_reg_file_sb;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  reg_file_sb_if #(.XLEN(32), .NREGS(32), .NREAD(2)) u_if ();
  reg_file_sb_if #(.XLEN(64), .NREGS(16), .NREAD(3)) w_if ();

  reg_file_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1'b1), .BYPASS(1'b1))
    dut (.clk(clk), .reset_n(reset_n), .bus(u_if.slave));

  reg_file_sb #(.XLEN(64), .NREGS(16), .NREAD(3), .ZERO_REG(1'b0), .BYPASS(1'b1))
    dut16 (.clk(clk), .reset_n(reset_n), .bus(w_if.slave));

  // Reference model of the default instance: architectural values and pending set.
  logic [31:0] m_reg [32];
  logic [31:0] m_busy;

  function automatic logic m_wb_hits(input logic [4:0] a);
    return u_if.wb_valid && (u_if.wb_addr == a);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (m_wb_hits(a)) return u_if.wb_data;
    return m_reg[a];
  endfunction

  function automatic logic m_rbusy(input logic [4:0] a);
    return (a != 0) && m_busy[a] && !m_wb_hits(a);
  endfunction

  function automatic logic m_ready(input logic [4:0] a);
    return (a == 0) || !m_busy[a] || m_wb_hits(a);
  endfunction

  task automatic m_edge();
    logic acc;
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) m_reg[i] = '0;
      m_busy = '0;
    end else begin
      acc = u_if.issue_valid && m_ready(u_if.issue_addr) && !u_if.flush;
      if (u_if.wb_valid && u_if.wb_addr != 0) m_reg[u_if.wb_addr] = u_if.wb_data;
      if (u_if.flush) m_busy = '0;
      else begin
        if (u_if.wb_valid) m_busy[u_if.wb_addr] = 1'b0;
        if (acc && u_if.issue_addr != 0) m_busy[u_if.issue_addr] = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    u_if.issue_valid = 0; u_if.wb_valid = 0; u_if.flush = 0;
    w_if.issue_valid = 0; w_if.wb_valid = 0; w_if.flush = 0;
  endtask

  task automatic test_reset();
    reset_n = 0;
    idle();
    u_if.rd_addr = '0; u_if.issue_addr = 5'd5; u_if.wb_data = '0; u_if.wb_addr = '0;
    w_if.rd_addr = '0; w_if.issue_addr = '0; w_if.wb_addr = '0; w_if.wb_data = '0;
    u_if.wb_valid = 1; u_if.wb_addr = 5'd5; u_if.wb_data = 32'hDEAD_BEEF;
    u_if.issue_valid = 1;
    cycle();
    cycle();
    reset_n = 1;
    idle();
    u_if.rd_addr[4:0] = 5'd5;
    #1;
    n_checks++;
    if (u_if.rd_data[31:0] !== 32'h0) begin
      n_errors++; $display("FAIL reset_x5: got %h expected %h", u_if.rd_data[31:0], 32'h0);
    end
    n_checks++;
    if (u_if.busy_count !== 6'd0) begin
      n_errors++; $display("FAIL reset_count: got %0d expected 0", u_if.busy_count);
    end
    n_checks++;
    if (w_if.busy_count !== 5'd0) begin
      n_errors++; $display("FAIL reset_count16: got %0d expected 0", w_if.busy_count);
    end
    for (int a = 0; a < 32; a++) begin
      u_if.issue_addr = 5'(a);
      #1;
      n_checks++;
      if (u_if.issue_ready !== 1'b1) begin
        n_errors++; $display("FAIL reset_ready[%0d]: got %b expected 1", a, u_if.issue_ready);
      end
    end
  endtask

  task automatic test_bypass();
    u_if.wb_valid = 1; u_if.wb_addr = 5'd7; u_if.wb_data = 32'h1234_5678;
    u_if.rd_addr[4:0] = 5'd7;
    #1;
    n_checks++;
    if (u_if.rd_data[31:0] !== 32'h1234_5678) begin
      n_errors++; $display("FAIL bypass_same_cycle: got %h expected %h", u_if.rd_data[31:0], 32'h1234_5678);
    end
    cycle();
    u_if.wb_valid = 0;
    #1;
    n_checks++;
    if (u_if.rd_data[31:0] !== 32'h1234_5678) begin
      n_errors++; $display("FAIL array_after_wb: got %h expected %h", u_if.rd_data[31:0], 32'h1234_5678);
    end
    u_if.wb_valid = 1; u_if.wb_addr = 5'd0; u_if.wb_data = 32'hFFFF_FFFF;
    u_if.rd_addr[9:5] = 5'd0;
    #1;
    n_checks++;
    if (u_if.rd_data[63:32] !== 32'h0) begin
      n_errors++; $display("FAIL x0_bypass: got %h expected %h", u_if.rd_data[63:32], 32'h0);
    end
    cycle();
    u_if.wb_valid = 0;
    #1;
    n_checks++;
    if (u_if.rd_data[63:32] !== 32'h0) begin
      n_errors++; $display("FAIL x0_after_wb: got %h expected %h", u_if.rd_data[63:32], 32'h0);
    end
  endtask

  task automatic test_scoreboard();
    u_if.issue_valid = 1; u_if.issue_addr = 5'd3; u_if.rd_addr[4:0] = 5'd3;
    cycle();
    u_if.issue_valid = 0;
    #1;
    n_checks++;
    if (u_if.busy_count !== 6'd1) begin
      n_errors++; $display("FAIL issue_count: got %0d expected 1", u_if.busy_count);
    end
    n_checks++;
    if (u_if.rd_busy[0] !== 1'b1) begin
      n_errors++; $display("FAIL issue_rd_busy: got %b expected 1", u_if.rd_busy[0]);
    end
    u_if.issue_valid = 1;
    #1;
    n_checks++;
    if (u_if.issue_ready !== 1'b0) begin
      n_errors++; $display("FAIL reissue_ready: got %b expected 0", u_if.issue_ready);
    end
    cycle();
    u_if.issue_valid = 0;
    #1;
    n_checks++;
    if (u_if.busy_count !== 6'd1) begin
      n_errors++; $display("FAIL reissue_count: got %0d expected 1", u_if.busy_count);
    end
    u_if.wb_valid = 1; u_if.wb_addr = 5'd3; u_if.wb_data = 32'h0000_0033;
    #1;
    n_checks++;
    if (u_if.rd_busy[0] !== 1'b0) begin
      n_errors++; $display("FAIL wb_rd_busy: got %b expected 0", u_if.rd_busy[0]);
    end
    cycle();
    u_if.wb_valid = 0;
    #1;
    n_checks++;
    if (u_if.busy_count !== 6'd0) begin
      n_errors++; $display("FAIL wb_count: got %0d expected 0", u_if.busy_count);
    end
  endtask

  task automatic test_simultaneous();
    u_if.issue_valid = 1; u_if.issue_addr = 5'd9; u_if.rd_addr[4:0] = 5'd9;
    cycle();
    u_if.wb_valid = 1; u_if.wb_addr = 5'd9; u_if.wb_data = 32'hCAFE_0009;
    #1;
    n_checks++;
    if (u_if.issue_ready !== 1'b1) begin
      n_errors++; $display("FAIL simul_ready: got %b expected 1", u_if.issue_ready);
    end
    cycle();
    idle();
    #1;
    n_checks++;
    if (u_if.rd_busy[0] !== 1'b1) begin
      n_errors++; $display("FAIL simul_busy: got %b expected 1", u_if.rd_busy[0]);
    end
    n_checks++;
    if (u_if.busy_count !== 6'd1) begin
      n_errors++; $display("FAIL simul_count: got %0d expected 1", u_if.busy_count);
    end
    n_checks++;
    if (u_if.rd_data[31:0] !== 32'hCAFE_0009) begin
      n_errors++; $display("FAIL simul_data: got %h expected %h", u_if.rd_data[31:0], 32'hCAFE_0009);
    end
    u_if.wb_valid = 1; u_if.wb_addr = 5'd9;
    cycle();
    idle();
  endtask

  task automatic test_flush();
    u_if.issue_valid = 1;
    u_if.issue_addr = 5'd1; cycle();
    u_if.issue_addr = 5'd2; cycle();
    u_if.issue_addr = 5'd4; cycle();
    u_if.issue_valid = 0;
    #1;
    n_checks++;
    if (u_if.busy_count !== 6'd3) begin
      n_errors++; $display("FAIL flush_pre_count: got %0d expected 3", u_if.busy_count);
    end
    u_if.flush = 1; u_if.issue_valid = 1; u_if.issue_addr = 5'd6;
    u_if.wb_valid = 1; u_if.wb_addr = 5'd2; u_if.wb_data = 32'hA5A5_A5A5;
    cycle();
    idle();
    u_if.rd_addr[4:0] = 5'd6; u_if.rd_addr[9:5] = 5'd2;
    #1;
    n_checks++;
    if (u_if.busy_count !== 6'd0) begin
      n_errors++; $display("FAIL flush_count: got %0d expected 0", u_if.busy_count);
    end
    n_checks++;
    if (u_if.rd_busy[0] !== 1'b0) begin
      n_errors++; $display("FAIL flush_x6_busy: got %b expected 0", u_if.rd_busy[0]);
    end
    n_checks++;
    if (u_if.rd_data[63:32] !== 32'hA5A5_A5A5) begin
      n_errors++; $display("FAIL flush_x2_data: got %h expected %h", u_if.rd_data[63:32], 32'hA5A5_A5A5);
    end
  endtask

  task automatic test_random();
    logic [4:0] a0, a1;
    for (int n = 0; n < 400; n++) begin
      reset_n          = ($urandom_range(0, 79) != 0);
      u_if.issue_valid = $urandom_range(0, 1);
      u_if.issue_addr  = 5'($urandom_range(0, 7));
      u_if.wb_valid    = $urandom_range(0, 1);
      u_if.wb_addr     = 5'($urandom_range(0, 7));
      u_if.wb_data     = $urandom;
      u_if.flush       = ($urandom_range(0, 15) == 0);
      a0 = 5'($urandom_range(0, 7));
      a1 = 5'($urandom_range(0, 7));
      u_if.rd_addr = {a1, a0};
      #1;
      n_checks++;
      if (u_if.rd_data !== {m_read(a1), m_read(a0)}) begin
        n_errors++; $display("FAIL rand_rd_data[%0d]: got %h expected %h", n, u_if.rd_data, {m_read(a1), m_read(a0)});
      end
      n_checks++;
      if (u_if.rd_busy !== {m_rbusy(a1), m_rbusy(a0)}) begin
        n_errors++; $display("FAIL rand_rd_busy[%0d]: got %b expected %b", n, u_if.rd_busy, {m_rbusy(a1), m_rbusy(a0)});
      end
      n_checks++;
      if (u_if.issue_ready !== m_ready(u_if.issue_addr)) begin
        n_errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", n, u_if.issue_ready, m_ready(u_if.issue_addr));
      end
      n_checks++;
      if (u_if.busy_count !== 6'($countones(m_busy))) begin
        n_errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", n, u_if.busy_count, $countones(m_busy));
      end
      cycle();
    end
    reset_n = 1;
    idle();
    cycle();
  endtask

  task automatic test_params();
    w_if.wb_valid = 1; w_if.wb_addr = 4'd0; w_if.wb_data = 64'h0123_4567_89AB_CDEF;
    cycle();
    w_if.wb_valid = 0;
    w_if.rd_addr = '0;
    #1;
    for (int p = 0; p < 3; p++) begin
      n_checks++;
      if (w_if.rd_data[p*64 +: 64] !== 64'h0123_4567_89AB_CDEF) begin
        n_errors++; $display("FAIL p16_x0_port%0d: got %h expected %h", p, w_if.rd_data[p*64 +: 64], 64'h0123_4567_89AB_CDEF);
      end
    end
    w_if.issue_valid = 1;
    for (int r = 0; r < 16; r++) begin
      w_if.issue_addr = 4'(r);
      cycle();
    end
    w_if.issue_valid = 0;
    w_if.issue_addr = 4'd0;
    #1;
    n_checks++;
    if (w_if.busy_count !== 5'd16) begin
      n_errors++; $display("FAIL p16_count: got %0d expected 16", w_if.busy_count);
    end
    n_checks++;
    if (w_if.issue_ready !== 1'b0) begin
      n_errors++; $display("FAIL p16_x0_ready: got %b expected 0", w_if.issue_ready);
    end
    n_checks++;
    if (w_if.rd_busy !== 3'b111) begin
      n_errors++; $display("FAIL p16_x0_rd_busy: got %b expected 111", w_if.rd_busy);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_scoreboard();
    test_simultaneous();
    test_flush();
    test_random();
    test_params();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
